circle_engine: RTL and testbench

- Parametrised midpoint-circle rasteriser. Accepts a centre, radius and colour through a start handshake and emits a pixel stream of at most one pixel per clock.
- The x, y, colour and plot outputs connect directly to vga_adapter.
- Replaces the fixed-centre, fixed-radius circle logic inside the screen-fill controller.
- Adds runtime geometry, per-pixel screen clipping, a busy/done handshake and an optional filled mode.

---
 rtl/circle_engine_if.sv | 30 +++
 rtl/circle_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_circle_engine.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circle_engine_if.sv
// Start handshake and pixel stream between circle_engine and its client.
// master drives the draw request; slave (the engine) drives the pixel stream.
interface circle_engine_if #(
    parameter int unsigned X_WIDTH      = 8,
    parameter int unsigned Y_WIDTH      = 7,
    parameter int unsigned R_WIDTH      = 7,
    parameter int unsigned COLOUR_WIDTH = 3
);
    logic                    start;
    logic [X_WIDTH-1:0]      cx;
    logic [Y_WIDTH-1:0]      cy;
    logic [R_WIDTH-1:0]      radius;
    logic [COLOUR_WIDTH-1:0] colour_in;
    logic                    busy;
    logic                    done;
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [COLOUR_WIDTH-1:0] colour;
    logic                    plot;

    modport master (
        output start, cx, cy, radius, colour_in,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  start, cx, cy, radius, colour_in,
        output busy, done, x, y, colour, plot
    );
endinterface

// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser streaming one candidate pixel per clock to vga_adapter.
// Define CIRCLE_FILL_EN to draw filled discs as horizontal spans instead of the outline.
module circle_engine #(
    parameter int unsigned X_WIDTH       = 8,
    parameter int unsigned Y_WIDTH       = 7,
    parameter int unsigned R_WIDTH       = 7,
    parameter int unsigned COLOUR_WIDTH  = 3,
    parameter int unsigned SCREEN_WIDTH  = 160,
    parameter int unsigned SCREEN_HEIGHT = 120
) (
    input logic            CLOCK_50,
    input logic            resetn,
    circle_engine_if.slave bus
);
    // oy may pass ox by one on the last step, and ox may drop to -1 when radius is 0.
    localparam int unsigned OW = R_WIDTH + 1;
    localparam int unsigned CW = R_WIDTH + 3;
    localparam int unsigned XW = ((X_WIDTH > OW) ? X_WIDTH : OW) + 2;
    localparam int unsigned YW = ((Y_WIDTH > OW) ? Y_WIDTH : OW) + 2;
    localparam logic signed [CW-1:0] CritOne = CW'(1);

    typedef enum logic [2:0] {StIdle, StInit, StEmit, StStep, StFin} state_e;

    state_e                  state_q, state_d;
    logic [X_WIDTH-1:0]      cx_q, cx_d;
    logic [Y_WIDTH-1:0]      cy_q, cy_d;
    logic [R_WIDTH-1:0]      r_q, r_d;
    logic [COLOUR_WIDTH-1:0] col_q, col_d;
    logic [OW-1:0]           ox_q, ox_d, oy_q, oy_d;
    logic signed [CW-1:0]    crit_q, crit_d;
    logic [X_WIDTH-1:0]      x_q, x_d;
    logic [Y_WIDTH-1:0]      y_q, y_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    logic                    plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic signed [XW-1:0]    cx_s, ox_x, oy_x, px;
    logic signed [YW-1:0]    cy_s, ox_y, oy_y, py;
    logic signed [CW-1:0]    oy_n, ox_n;
    logic                    on_screen, crit_le0;

    assign cx_s = XW'(cx_q);
    assign ox_x = XW'(ox_q);
    assign oy_x = XW'(oy_q);
    assign cy_s = YW'(cy_q);
    assign ox_y = YW'(ox_q);
    assign oy_y = YW'(oy_q);

`ifdef CIRCLE_FILL_EN
    localparam logic signed [XW-1:0] XOne = XW'(1);

    // Span 0/1 are rows cy+-oy with half-width ox; spans 2/3 are rows cy+-ox with half-width oy.
    logic [1:0]           sp_q, sp_d;
    logic signed [XW-1:0] xoff_q, xoff_d, half;
    logic                 span_end;

    always_comb begin
        half = sp_q[1] ? oy_x : ox_x;
        px   = cx_s + xoff_q;
        unique case (sp_q)
            2'd0:    py = cy_s + oy_y;
            2'd1:    py = cy_s - oy_y;
            2'd2:    py = cy_s + ox_y;
            default: py = cy_s - ox_y;
        endcase
    end

    assign span_end = (xoff_q == half);
`else
    logic [2:0] k_q, k_d;

    always_comb begin
        unique case (k_q)
            3'd0: begin px = cx_s + ox_x; py = cy_s + oy_y; end
            3'd1: begin px = cx_s + oy_x; py = cy_s + ox_y; end
            3'd2: begin px = cx_s - ox_x; py = cy_s + oy_y; end
            3'd3: begin px = cx_s - oy_x; py = cy_s + ox_y; end
            3'd4: begin px = cx_s - ox_x; py = cy_s - oy_y; end
            3'd5: begin px = cx_s - oy_x; py = cy_s - ox_y; end
            3'd6: begin px = cx_s + ox_x; py = cy_s - oy_y; end
            default: begin px = cx_s + oy_x; py = cy_s - ox_y; end
        endcase
    end
`endif

    assign on_screen = !px[XW-1] && ($unsigned(px) < XW'(SCREEN_WIDTH)) &&
                       !py[YW-1] && ($unsigned(py) < YW'(SCREEN_HEIGHT));

    assign crit_le0 = crit_q[CW-1] || (crit_q == '0);
    assign oy_n     = $signed(CW'(oy_q)) + CritOne;
    assign ox_n     = crit_le0 ? $signed(CW'(ox_q)) : $signed(CW'(ox_q)) - CritOne;

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        r_d      = r_q;
        col_d    = col_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
`ifdef CIRCLE_FILL_EN
        sp_d     = sp_q;
        xoff_d   = xoff_q;
`else
        k_d      = k_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cx_d    = bus.cx;
                    cy_d    = bus.cy;
                    r_d     = bus.radius;
                    col_d   = bus.colour_in;
                    busy_d  = 1'b1;
                    state_d = StInit;
                end
            end
            StInit: begin
                ox_d    = OW'(r_q);
                oy_d    = '0;
                crit_d  = CritOne - $signed(CW'(r_q));
`ifdef CIRCLE_FILL_EN
                sp_d    = '0;
                xoff_d  = -$signed(XW'(r_q));
`else
                k_d     = '0;
`endif
                state_d = StEmit;
            end
            StEmit: begin
                // Clipped pixels still take their cycle; only the strobe is suppressed.
                x_d      = px[X_WIDTH-1:0];
                y_d      = py[Y_WIDTH-1:0];
                colour_d = col_q;
                plot_d   = on_screen;
`ifdef CIRCLE_FILL_EN
                if (!span_end) begin
                    xoff_d = xoff_q + XOne;
                end else if (sp_q == 2'd3) begin
                    state_d = StStep;
                end else begin
                    sp_d   = sp_q + 2'd1;
                    xoff_d = (sp_q == 2'd0) ? -ox_x : -oy_x;
                end
`else
                if (k_q == 3'd7) begin
                    state_d = StStep;
                end else begin
                    k_d = k_q + 3'd1;
                end
`endif
            end
            StStep: begin
                oy_d   = oy_n[OW-1:0];
                ox_d   = ox_n[OW-1:0];
                crit_d = crit_le0 ? (crit_q + oy_n + oy_n + CritOne)
                                  : (crit_q + oy_n + oy_n - ox_n - ox_n + CritOne);
                if (oy_n > ox_n) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else begin
`ifdef CIRCLE_FILL_EN
                    sp_d   = '0;
                    xoff_d = -$signed(XW'(ox_n[OW-1:0]));
`else
                    k_d    = '0;
`endif
                    state_d = StEmit;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cx_q     <= '0;
            cy_q     <= '0;
            r_q      <= '0;
            col_q    <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            crit_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CIRCLE_FILL_EN
            sp_q     <= '0;
            xoff_q   <= '0;
`else
            k_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            r_q      <= r_d;
            col_q    <= col_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            crit_q   <= crit_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CIRCLE_FILL_EN
            sp_q     <= sp_d;
            xoff_q   <= xoff_d;
`else
            k_q      <= k_d;
`endif
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_circle_engine.sv
// Randomised bench for circle_engine: a pixel-list model predicts every output cycle,
// plus literal checks of the documented circles. Works with or without CIRCLE_FILL_EN.
module tb_circle_engine;
    typedef struct {
        bit pix;
        bit plot;
        int x;
        int y;
        bit busy;
        bit done;
    } rec_t;

    typedef struct {
        int cyc;
        int x;
        int y;
    } pix_t;

    logic clk = 1'b0;
    logic resetn;

    circle_engine_if #(.X_WIDTH(8), .Y_WIDTH(7), .R_WIDTH(7), .COLOUR_WIDTH(3)) bus ();

    circle_engine dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    rec_t exp_q[$];
    int   acc_log[$];
    pix_t plot_log[$];
    int   done_log[$];
    bit   e_plot = 0, e_busy = 0, e_done = 0;
    int   e_x = 0, e_y = 0, e_col = 0, lat_col = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ctl(bit b, bit d);
        rec_t r;
        r.pix = 0; r.plot = 0; r.x = 0; r.y = 0; r.busy = b; r.done = d;
        exp_q.push_back(r);
    endfunction

    function automatic void push_pix(int px, int py);
        rec_t r;
        r.pix  = 1;
        r.plot = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
        r.x    = px & 255;
        r.y    = py & 127;
        r.busy = 1;
        r.done = 0;
        exp_q.push_back(r);
    endfunction

    // Output timeline after the accept edge: accept, INIT, then pixels and steps, FIN.
    function automatic void build(int cx, int cy, int r);
        int ox, oy, crit;
        ox = r; oy = 0; crit = 1 - r;
        push_ctl(1, 0);
        push_ctl(1, 0);
        while (1) begin
`ifdef CIRCLE_FILL_EN
            for (int s = 0; s < 4; s++) begin
                int h, row;
                h   = (s < 2) ? ox : oy;
                row = (s == 0) ? cy + oy : (s == 1) ? cy - oy : (s == 2) ? cy + ox : cy - ox;
                for (int dx = -h; dx <= h; dx++) push_pix(cx + dx, row);
            end
`else
            push_pix(cx + ox, cy + oy); push_pix(cx + oy, cy + ox);
            push_pix(cx - ox, cy + oy); push_pix(cx - oy, cy + ox);
            push_pix(cx - ox, cy - oy); push_pix(cx - oy, cy - ox);
            push_pix(cx + ox, cy - oy); push_pix(cx + oy, cy - ox);
`endif
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
            if (oy > ox) break;
            push_ctl(1, 0);
        end
        push_ctl(0, 1);
        push_ctl(0, 0);
    endfunction

    initial forever begin
        rec_t r;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            exp_q.delete();
            e_plot = 0; e_busy = 0; e_done = 0; e_x = 0; e_y = 0; e_col = 0;
        end else begin
            cyc++;
            if (exp_q.size() == 0 && bus.start === 1'b1) begin
                acc_log.push_back(cyc);
                lat_col = int'(bus.colour_in);
                build(int'(bus.cx), int'(bus.cy), int'(bus.radius));
            end
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                e_plot = r.plot; e_busy = r.busy; e_done = r.done;
                if (r.pix) begin
                    e_x = r.x; e_y = r.y; e_col = lat_col;
                end
            end else begin
                e_plot = 0; e_busy = 0; e_done = 0;
            end
        end
    end

    initial forever begin
        pix_t p;
        @(negedge clk);
        chk("plot",   int'(bus.plot),   int'(e_plot));
        chk("busy",   int'(bus.busy),   int'(e_busy));
        chk("done",   int'(bus.done),   int'(e_done));
        chk("x",      int'(bus.x),      e_x);
        chk("y",      int'(bus.y),      e_y);
        chk("colour", int'(bus.colour), e_col);
        if (bus.plot === 1'b1) begin
            p.cyc = cyc; p.x = int'(bus.x); p.y = int'(bus.y);
            plot_log.push_back(p);
        end
        if (bus.done === 1'b1) done_log.push_back(cyc);
    end

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("idle_timeout", 0, 1);
    endtask

    task automatic draw(input int cxi, input int cyi, input int r, input int col,
                        output int pb, output int db, output int acc);
        wait_idle();
        pb = plot_log.size();
        db = done_log.size();
        bus.cx = 8'(cxi); bus.cy = 7'(cyi); bus.radius = 7'(r); bus.colour_in = 3'(col);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        acc = (acc_log.size() != 0) ? acc_log[acc_log.size() - 1] : -1;
        // Inputs after acceptance must have no effect on the draw.
        bus.cx = 8'($urandom); bus.cy = 7'($urandom);
        bus.radius = 7'($urandom); bus.colour_in = 3'($urandom);
        wait_idle();
    endtask

    initial begin
        int pb, db, acc, n, a_base, d_base, cnt, hit1, hit2, fp;
        bus.start = 1'b0; bus.cx = '0; bus.cy = '0; bus.radius = '0; bus.colour_in = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_colour", int'(bus.colour), 0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);

        // Centred radius-3 circle
        draw(80, 60, 3, 1, pb, db, acc);
        cnt = plot_log.size() - pb;
`ifdef CIRCLE_FILL_EN
        chk("fill_count", cnt, 56);
        if (cnt >= 7) begin
            for (int i = 0; i < 7; i++) begin
                chk("fill_row_y", plot_log[pb + i].y, 60);
                chk("fill_row_x", plot_log[pb + i].x, 77 + i);
            end
        end
`else
        chk("outline_count", cnt, 24);
        if (cnt == 24) begin
            hit1 = 0; hit2 = 0;
            for (int i = 16; i < 24; i++) begin
                if (plot_log[pb + i].x == 82 && plot_log[pb + i].y == 62) hit1 = 1;
                if (plot_log[pb + i].x == 78 && plot_log[pb + i].y == 58) hit2 = 1;
            end
            chk("final_82_62", hit1, 1);
            chk("final_78_58", hit2, 1);
            chk("first_x", plot_log[pb].x, 83);
            chk("first_y", plot_log[pb].y, 60);
        end
        if (done_log.size() > db) chk("draw_len", done_log[db] - acc, 28);
`endif
        if (cnt > 0) chk("first_latency", plot_log[pb].cyc - acc, 2);
        chk("done_count", done_log.size() - db, 1);
        if (cnt > 0 && done_log.size() > db)
            chk("done_after_last", done_log[db] - plot_log[plot_log.size() - 1].cyc, 1);

        // Left-edge clipping
        draw(2, 60, 3, 6, pb, db, acc);
`ifdef CIRCLE_FILL_EN
        chk("clip_count", plot_log.size() - pb, 52);
`else
        chk("clip_count", plot_log.size() - pb, 20);
        if (done_log.size() > db) chk("clip_len", done_log[db] - acc, 28);
`endif

        // Radius zero
        draw(10, 10, 0, 2, pb, db, acc);
        cnt = plot_log.size() - pb;
`ifdef CIRCLE_FILL_EN
        chk("r0_count", cnt, 4);
`else
        chk("r0_count", cnt, 8);
`endif
        for (int i = pb; i < plot_log.size(); i++) begin
            chk("r0_x", plot_log[i].x, 10);
            chk("r0_y", plot_log[i].y, 10);
        end
        chk("r0_done", done_log.size() - db, 1);

        // start held through a draw, cx changed mid-draw
        wait_idle();
        a_base = acc_log.size(); d_base = done_log.size();
        bus.cx = 30; bus.cy = 40; bus.radius = 2; bus.colour_in = 5; bus.start = 1'b1;
        repeat (5) @(negedge clk);
        bus.cx = 100;
        n = 0;
        while (acc_log.size() < a_base + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("held_accepts", acc_log.size() - a_base, 2);
        wait_idle();
        if (acc_log.size() >= a_base + 2 && done_log.size() > d_base) begin
            chk("reaccept_gap", acc_log[a_base + 1] - done_log[d_base], 2);
            fp = -1;
            for (int i = 0; i < plot_log.size(); i++)
                if (fp < 0 && plot_log[i].cyc > acc_log[a_base + 1]) fp = i;
            if (fp >= 0) begin
                chk("held_latency", plot_log[fp].cyc - acc_log[a_base + 1], 2);
`ifdef CIRCLE_FILL_EN
                chk("held_first_x", plot_log[fp].x, 98);
`else
                chk("held_first_x", plot_log[fp].x, 102);
`endif
                chk("held_first_y", plot_log[fp].y, 40);
            end else chk("held_second_plots", 0, 1);
        end

        // Reset mid-draw aborts without done
        wait_idle();
        d_base = done_log.size();
        bus.cx = 80; bus.cy = 60; bus.radius = 10; bus.colour_in = 2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_busy", int'(bus.busy), 1);
        #2 resetn = 1'b0;
        #1;
        chk("abort_plot", int'(bus.plot), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_log.size() - d_base, 0);
        draw(80, 60, 3, 4, pb, db, acc);
`ifdef CIRCLE_FILL_EN
        chk("post_rst_count", plot_log.size() - pb, 56);
`else
        chk("post_rst_count", plot_log.size() - pb, 24);
`endif

        // Random geometry, plus one large clipped circle
        for (int i = 0; i < 12; i++) begin
            draw(int'($urandom_range(255, 0)), int'($urandom_range(127, 0)),
                 int'($urandom_range(15, 0)), int'($urandom_range(7, 0)), pb, db, acc);
            chk("rand_done", done_log.size() - db, 1);
        end
        draw(80, 60, 40, 7, pb, db, acc);
        chk("big_done", done_log.size() - db, 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
